decoder_in_capture: RTL and testbench
=====================================

# decoder_in_capture

Input-capture stage feeding the decoder project's 7-bit `io_in` code input. It synchronises the asynchronous pad bus and debounces it, requiring a programmable number of stable samples. Each newly settled code is pushed into a 2-entry FIFO. The decoder drains the FIFO over a valid/ready handshake.

## Interface
Parameters:
- `WIDTH`, 7: code width; matches decoder `io_in`.
- `STABLE_CYCLES`, 4: consecutive equal synchronised samples required after a change; legal range 1..15.

Ports:
- `clock`  in  1  single system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `io_in`  in  WIDTH  raw asynchronous pad bus.
- `code_out`  out  WIDTH  FIFO head code; reset 0.
- `code_valid`  out  1  FIFO non-empty; reset 0.
- `code_ready`  in  1  decoder accepts the head when high together with `code_valid`.
- `overflow`  out  1  sticky: a settled code was dropped; reset 0.
- `drop_cnt`  out  8  saturating dropped-code count; reset 0; present only with `DECODER_IN_DROP_CNT_EN`.

## Operation
- Synchroniser:
  - Two flops in series, `s1` then `s2`, both reset to 0.
  - No logic sits between them.
- Debouncer state:
  - `cand` (WIDTH), `cnt` (4 bit), `last` (WIDTH); all reset to 0.
  - When `s2 != cand`: `cand <= s2` and `cnt <= 0`.
  - Otherwise, when `cnt < STABLE_CYCLES`: `cnt <= cnt + 1`.
  - `cnt` saturates at STABLE_CYCLES.
- Settle event:
  - Fires in a cycle where `s2 == cand`, `cnt == STABLE_CYCLES-1` and `cand != last`.
  - On the event, `last <= cand` and `cand` is pushed into the FIFO.
  - Since `last` resets to 0, an all-zero code never emits until a different code has settled first.
- FIFO:
  - Depth 2; read/write pointers plus a count.
  - Pop when `code_valid && code_ready`.
- Push/pop cases:
  - Push while not full: write the code.
  - Push while full with a pop in the same cycle: accept the push; the count stays 2.
  - Push while full without a pop: drop the new code, set `overflow`, increment `drop_cnt`. FIFO contents are unchanged.
  - Push and pop with count 1: count stays 1, and the head becomes the new code.
  - Pop while empty cannot occur, because `code_valid` is 0.
- Handshake rules:
  - `code_out` and `code_valid` are registered and driven directly from FIFO state.
  - `code_out` is held stable while `code_valid && !code_ready`.
  - `code_valid` never drops without a pop.
- Bounce:
  - Any change on `s2` before the event restarts the count.
  - Glitches shorter than STABLE_CYCLES synchronised samples produce no push.
- `overflow` clears only on `reset`.

## Timing
- Input to valid latency:
  - Let edge 1 be the first edge at which `s1` captures the new stable value.
  - `cand` updates at edge 3.
  - The push, and `code_valid` rising, occur at edge `3+STABLE_CYCLES` (edge 7 for the default).
- Handshake: a pop at edge N presents the next entry, or drops `code_valid`, immediately after edge N.
- Throughput: at most one push per STABLE_CYCLES+1 cycles; one pop per cycle.
- No combinational path from `code_ready` to `code_valid` or `code_out`.
- Reset mid-operation:
  - Any cycle with `reset` high clears all state at that edge.
  - Queued codes are discarded and `code_valid` is 0 after the edge.
  - `reset` overrides a same-cycle push or pop.

## Configuration
- `DECODER_IN_DROP_CNT_EN` defined:
  - Adds the `drop_cnt` port and its 8-bit counter.
  - The counter increments on every drop and saturates at 255.
- Not defined: neither the port nor the counter exists. `overflow` is the only drop indication; all other behaviour is identical.

## Test plan
- Steady step, default parameters:
  - Stimulus: `io_in` 0→7'b1001111 with `code_ready=1`.
  - Response: `code_valid` pulses for one cycle at edge 7 with `code_out=7'h4F`, and no further pushes follow.
- Bounce:
  - Stimulus: `io_in` toggles 7'h4F/7'h00 every 2 cycles for 20 cycles, then holds 7'h4F.
  - Response: exactly one push of 7'h4F, at 3+STABLE_CYCLES edges after the hold starts.
- Backpressure:
  - Stimulus: `code_ready=0`; settle the codes 7'h01, 7'h02, then 7'h03.
  - Response:
    - The FIFO holds 7'h01 then 7'h02, and `code_out` stays 7'h01.
    - `overflow` goes to 1 when 7'h03 settles.
    - With the macro defined, `drop_cnt=1`.
    - Raising `code_ready` yields 7'h01 then 7'h02.
- Full with simultaneous pop:
  - Stimulus: FIFO full and `code_ready=1` in the cycle a third code settles.
  - Response: the code is accepted, `overflow` stays 0, and the output order is preserved.
- Reset mid-operation:
  - Stimulus: assert `reset` for one cycle while 2 entries are queued and a debounce count is in progress.
  - Response:
    - All outputs are 0 after the edge.
    - The in-progress code emits only after a fresh 3+STABLE_CYCLES edges.
- Repeat suppression:
  - Stimulus: settle 7'h4F, glitch to 7'h00 for 1 sample, return to 7'h4F.
  - Response: a single push.

Source files
------------

// File: rtl/decoder_in_capture.sv
// decoder_in_capture
//   Input-capture stage for the decoder's code input. The asynchronous pad
//   bus goes through a two-flop synchroniser and then a debouncer. Each newly
//   settled code is pushed into a 2-entry FIFO, and the decoder drains that
//   FIFO over a valid/ready handshake.
//
// Parameters
//   WIDTH          code width (matches decoder io_in)
//   STABLE_CYCLES  equal synchronised samples needed after a change (1..15)
//
// Ports
//   clock       in   system clock, rising edge
//   reset       in   synchronous, active-high reset
//   io_in       in   raw asynchronous pad bus
//   code_out    out  FIFO head code (registered)
//   code_valid  out  FIFO non-empty (registered)
//   code_ready  in   decoder accepts head when high with code_valid
//   overflow    out  sticky: a settled code was dropped
//   drop_cnt    out  saturating dropped-code count (DECODER_IN_DROP_CNT_EN only)
//
// Optional feature macro: DECODER_IN_DROP_CNT_EN
module decoder_in_capture #(
  parameter int WIDTH         = 7,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] io_in,
  output logic [WIDTH-1:0] code_out,
  output logic             code_valid,
  input  logic             code_ready,
  output logic             overflow
`ifdef DECODER_IN_DROP_CNT_EN
  ,
  output logic [7:0]       drop_cnt
`endif
);

  localparam logic [3:0] CNT_SAT   = 4'(STABLE_CYCLES);
  localparam logic [3:0] CNT_FIRE  = 4'(STABLE_CYCLES - 1);
  localparam logic [1:0] FIFO_FULL = 2'd2;

  logic [WIDTH-1:0] s1_r;
  logic [WIDTH-1:0] s2_r;
  logic [WIDTH-1:0] cand_r;
  logic [WIDTH-1:0] last_r;
  logic [3:0]       cnt_r;

  logic             settle_s;
  logic             pop_s;
  logic             push_ok_s;
  logic             drop_s;

  logic [WIDTH-1:0] mem_r [2];
  logic [WIDTH-1:0] mem_n [2];
  logic             wr_ptr_r;
  logic             wr_ptr_n;
  logic             rd_ptr_r;
  logic             rd_ptr_n;
  logic [1:0]       count_r;
  logic [1:0]       count_n;
  logic [WIDTH-1:0] code_out_n;
  logic             code_valid_n;

  // A settle event fires once per stable period, and only for a code that
  // differs from the last one emitted (so a reset-valued zero never emits first).
  assign settle_s  = (s2_r == cand_r) && (cnt_r == CNT_FIRE) && (cand_r != last_r);
  assign pop_s     = code_valid && code_ready;
  // A full FIFO still takes the push when the head leaves in the same cycle.
  assign push_ok_s = settle_s && ((count_r != FIFO_FULL) || pop_s);
  assign drop_s    = settle_s && !push_ok_s;

  // Two-flop synchroniser for the asynchronous pad bus.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_r <= {WIDTH{1'b0}};
      s2_r <= {WIDTH{1'b0}};
    end else begin
      s1_r <= io_in;
      s2_r <= s1_r;
    end
  end

  // Debouncer: track the candidate code and how long it has been stable.
  always_ff @(posedge clock) begin
    if (reset) begin
      cand_r <= {WIDTH{1'b0}};
      cnt_r  <= 4'd0;
      last_r <= {WIDTH{1'b0}};
    end else begin
      if (s2_r != cand_r) begin
        cand_r <= s2_r;
        cnt_r  <= 4'd0;
      end else if (cnt_r < CNT_SAT) begin
        cnt_r  <= cnt_r + 4'd1;
      end else begin
        cnt_r  <= cnt_r;
      end
      if (settle_s) begin
        last_r <= cand_r;
      end else begin
        last_r <= last_r;
      end
    end
  end

  // FIFO next state; the outputs are computed from the post-edge FIFO state so
  // they can be registered without an extra cycle of latency.
  always_comb begin
    mem_n    = mem_r;
    wr_ptr_n = wr_ptr_r;
    rd_ptr_n = rd_ptr_r;
    count_n  = count_r;
    if (push_ok_s) begin
      mem_n[wr_ptr_r] = cand_r;
      wr_ptr_n        = ~wr_ptr_r;
    end else begin
      wr_ptr_n        = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_n = ~rd_ptr_r;
    end else begin
      rd_ptr_n = rd_ptr_r;
    end
    case ({push_ok_s, pop_s})
      2'b10:   count_n = count_r + 2'd1;
      2'b01:   count_n = count_r - 2'd1;
      default: count_n = count_r;
    endcase
    code_valid_n = (count_n != 2'd0);
    if (code_valid_n) begin
      code_out_n = mem_n[rd_ptr_n];
    end else begin
      code_out_n = code_out;
    end
  end

  // FIFO storage, pointers and the registered handshake outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_r[0]   <= {WIDTH{1'b0}};
      mem_r[1]   <= {WIDTH{1'b0}};
      wr_ptr_r   <= 1'b0;
      rd_ptr_r   <= 1'b0;
      count_r    <= 2'd0;
      code_out   <= {WIDTH{1'b0}};
      code_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      mem_r      <= mem_n;
      wr_ptr_r   <= wr_ptr_n;
      rd_ptr_r   <= rd_ptr_n;
      count_r    <= count_n;
      code_out   <= code_out_n;
      code_valid <= code_valid_n;
      overflow   <= overflow | drop_s;
    end
  end

`ifdef DECODER_IN_DROP_CNT_EN
  // Saturating count of settled codes dropped on a full FIFO.
  always_ff @(posedge clock) begin
    if (reset) begin
      drop_cnt <= 8'd0;
    end else if (drop_s && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end else begin
      drop_cnt <= drop_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_decoder_in_capture.sv
// Self-checking bench for decoder_in_capture. A reference model kept here
// derives settle events from the history of synchronised samples (a run of
// STABLE_CYCLES+1 equal samples that begins right after a change) and models
// the FIFO as a queue. Directed tests pin literal expectations, and a random
// phase follows.
module tb_decoder_in_capture;

  localparam int W = 7;
  localparam int S = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] io_in;
  logic [W-1:0] code_out;
  logic         code_valid;
  logic         code_ready;
  logic         overflow;
`ifdef DECODER_IN_DROP_CNT_EN
  logic [7:0]   drop_cnt;
`endif

  decoder_in_capture #(.WIDTH(W), .STABLE_CYCLES(S)) dut (
    .clock      (clock),
    .reset      (reset),
    .io_in      (io_in),
    .code_out   (code_out),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .overflow   (overflow)
`ifdef DECODER_IN_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] syn_q[$];   // synchronised sample after each edge
  bit           brk_q[$];   // 1 where that edge was a reset edge
  logic [W-1:0] exp_q[$];   // expected FIFO contents, head first
  logic [W-1:0] s1_m;
  logic [W-1:0] last_m;
  logic [W-1:0] v_m;
  bit           ovf_m;
  int           drops_m;
  bit           settle_m;
  bit           pop_m;
  int           n_m;
  int           st_m;

  always @(posedge clock) begin
    if (reset) begin
      s1_m = '0;
      syn_q.push_back('0);
      brk_q.push_back(1'b1);
      exp_q.delete();
      ovf_m   = 1'b0;
      drops_m = 0;
      last_m  = '0;
    end else begin
      // Settle: the last S+1 synchronised samples are equal, the run begins
      // right after a change, and the code differs from the last emitted one.
      settle_m = 1'b0;
      n_m  = syn_q.size();
      st_m = n_m - 1 - S;
      if (st_m >= 1) begin
        v_m = syn_q[n_m-1];
        settle_m = (v_m != last_m) && (brk_q[st_m] || (syn_q[st_m-1] != v_m));
        for (int i = st_m; i < n_m; i++) if (syn_q[i] != v_m) settle_m = 1'b0;
        for (int i = st_m + 1; i < n_m; i++) if (brk_q[i]) settle_m = 1'b0;
      end
      syn_q.push_back(s1_m);
      brk_q.push_back(1'b0);
      s1_m = io_in;
      pop_m = (exp_q.size() != 0) && code_ready;
      if (pop_m) void'(exp_q.pop_front());
      if (settle_m) begin
        last_m = v_m;
        if (exp_q.size() < 2) begin
          exp_q.push_back(v_m);
        end else begin
          ovf_m = 1'b1;
          if (drops_m < 255) drops_m++;
        end
      end
    end
  end

  // Compare the DUT outputs against the model on every cycle.
  always @(negedge clock) begin
    if (chk_en) begin
      check("code_valid", 32'(code_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) check("code_out", 32'(code_out), 32'(exp_q[0]));
      check("overflow", 32'(overflow), 32'(ovf_m));
`ifdef DECODER_IN_DROP_CNT_EN
      check("drop_cnt", 32'(drop_cnt), 32'(drops_m));
`endif
    end
  end

  task automatic do_reset();
    io_in = '0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
  endtask

  int hits;
  int at;
  int hold;
  logic [W-1:0] pick;

  initial begin
    reset = 1'b1;
    io_in = '0;
    code_ready = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
    chk_en = 1'b1;
    check("reset_valid", 32'(code_valid), 32'd0);
    check("reset_code", 32'(code_out), 32'd0);
    check("reset_ovf", 32'(overflow), 32'd0);

    // Steady step 0 -> 7'h4F: one valid cycle at edge 7.
    io_in = 7'h4F;
    tick(6);
    check("step_pre", 32'(code_valid), 32'd0);
    tick(1);
    check("step_valid", 32'(code_valid), 32'd1);
    check("step_code", 32'(code_out), 32'h4F);
    tick(1);
    check("step_post", 32'(code_valid), 32'd0);
    tick(20);

    // Bounce then hold.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      io_in = (i % 2 == 0) ? 7'h4F : 7'h00;
      tick(2);
    end
    io_in = 7'h4F;
    hits = 0;
    at = 0;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (code_valid) begin
        hits++;
        at = k;
      end
    end
    check("bounce_hits", 32'(hits), 32'd1);
    check("bounce_edge", 32'(at), 32'(S + 3));

    // Backpressure: 01, 02 queued, 03 dropped.
    do_reset();
    code_ready = 1'b0;
    io_in = 7'h01; tick(10);
    io_in = 7'h02; tick(10);
    check("bp_valid", 32'(code_valid), 32'd1);
    check("bp_head", 32'(code_out), 32'h01);
    check("bp_ovf0", 32'(overflow), 32'd0);
    io_in = 7'h03; tick(10);
    check("bp_ovf1", 32'(overflow), 32'd1);
    check("bp_head_held", 32'(code_out), 32'h01);
`ifdef DECODER_IN_DROP_CNT_EN
    check("bp_drops", 32'(drop_cnt), 32'd1);
`endif
    code_ready = 1'b1;
    tick(1);
    check("bp_second", 32'(code_out), 32'h02);
    tick(1);
    check("bp_empty", 32'(code_valid), 32'd0);

    // Full FIFO with a pop in the settle cycle.
    do_reset();
    code_ready = 1'b0;
    io_in = 7'h11; tick(10);
    io_in = 7'h12; tick(10);
    io_in = 7'h13;
    tick(6);
    code_ready = 1'b1;
    tick(1);
    check("fp_head", 32'(code_out), 32'h12);
    check("fp_ovf", 32'(overflow), 32'd0);
    tick(1);
    check("fp_next", 32'(code_out), 32'h13);
    tick(1);
    check("fp_empty", 32'(code_valid), 32'd0);

    // Reset mid-operation with two entries queued and a debounce in flight.
    do_reset();
    code_ready = 1'b0;
    io_in = 7'h21; tick(10);
    io_in = 7'h22; tick(10);
    io_in = 7'h24; tick(10);
    io_in = 7'h23; tick(3);
    reset = 1'b1;
    tick(1);
    check("mid_valid", 32'(code_valid), 32'd0);
    check("mid_code", 32'(code_out), 32'd0);
    check("mid_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    tick(S + 2);
    check("mid_pre", 32'(code_valid), 32'd0);
    tick(1);
    check("mid_emit", 32'(code_valid), 32'd1);
    check("mid_code23", 32'(code_out), 32'h23);

    // Repeat suppression: a one-sample glitch must not re-emit 7'h4F.
    code_ready = 1'b1;
    io_in = 7'h4F; tick(12);
    io_in = 7'h00; tick(1);
    io_in = 7'h4F;
    hits = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (code_valid) hits++;
    end
    check("repeat_hits", 32'(hits), 32'd0);

    // Random phase.
    hold = 0;
    for (int c = 0; c < 2500; c++) begin
      if (hold == 0) begin
        case ($urandom_range(0, 4))
          0:       pick = 7'h00;
          1:       pick = 7'h4F;
          2:       pick = 7'h01;
          3:       pick = 7'h7F;
          default: pick = 7'($urandom);
        endcase
        io_in = pick;
        hold = $urandom_range(1, 9);
      end
      hold--;
      code_ready = ((c / 400) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                        : ($urandom_range(0, 5) == 0);
      reset = ($urandom_range(0, 299) == 0);
      tick(1);
    end
    reset = 1'b0;
    code_ready = 1'b1;
    tick(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
